// File: rtl/lif_soma_array.sv
// lif_soma_array
// Membrane-voltage store for NUM_CH leaky integrate-and-fire neurons. One
// channel update is accepted per cycle from the time-multiplexed synapse
// summation front end. Each accepted update applies a proportional leak,
// integrates the input terms, clamps the result to [0, 2^WIDTH-1] and fires
// when the clamped value reaches THRESHOLD.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   i_valid       update request for channel i_ch this cycle
//   i_ch          target channel
//   i_sum_excit   excitatory sum (unsigned)
//   i_sum_inhibit inhibitory sum (unsigned, subtracted)
//   i_cond_decay  conductance decay term (unsigned, added)
//   o_voltage     flattened voltages, channel c at [c*WIDTH +: WIDTH]
//   o_spike       per-channel one-cycle spike pulse
//   o_refrac      channel is refractory (counter nonzero)
//   o_spike_cnt   total spikes since reset, wrapping
//   o_err         one-cycle pulse for i_valid with i_ch >= NUM_CH
module lif_soma_array #(
    parameter int unsigned       WIDTH         = 14,
    parameter int unsigned       NUM_CH        = 4,
    parameter logic [WIDTH-1:0]  THRESHOLD     = 14'h1300,
    parameter int unsigned       LEAK_SHIFT    = 4,
    parameter int unsigned       REFRAC_CYCLES = 3,
    parameter int unsigned       RESET_MODE    = 0,
    parameter int unsigned       CNT_W         = 16,
    localparam int unsigned      CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [CHW-1:0]           i_ch,
    input  logic [WIDTH-1:0]         i_sum_excit,
    input  logic [WIDTH-1:0]         i_sum_inhibit,
    input  logic [WIDTH-1:0]         i_cond_decay,
    output logic [NUM_CH*WIDTH-1:0]  o_voltage,
    output logic [NUM_CH-1:0]        o_spike,
    output logic [NUM_CH-1:0]        o_refrac,
    output logic [CNT_W-1:0]         o_spike_cnt,
    output logic                     o_err
);

    localparam int unsigned RCW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    // One bit beyond WIDTH+2: v + excit + decay can approach 3*2^WIDTH, and the
    // extra headroom keeps that worst case from wrapping before the clamp.
    localparam int unsigned AW  = WIDTH + 3;

    logic [WIDTH-1:0] v_q  [NUM_CH];
    logic [WIDTH-1:0] v_d  [NUM_CH];
    logic [RCW-1:0]   rc_q [NUM_CH];
    logic [RCW-1:0]   rc_d [NUM_CH];
    logic [NUM_CH-1:0] spike_q, spike_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic             ch_ok;
    logic             sel_idle;
    logic             accept;
    logic             fire;
    logic [WIDTH-1:0] v_sel;
    logic [WIDTH-1:0] leak;
    logic [AW-1:0]    n_sum;
    logic [WIDTH-1:0] ns;

    // Operand selection, integration and clamp for the addressed channel.
    always_comb begin
        ch_ok    = (32'(i_ch) < NUM_CH);
        v_sel    = '0;
        sel_idle = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(i_ch) == c) begin
                v_sel    = v_q[c];
                sel_idle = (rc_q[c] == '0);
            end
        end
        accept = i_valid && ch_ok && sel_idle;

        leak = (LEAK_SHIFT == 0) ? '0 : (v_sel >> LEAK_SHIFT);
        n_sum = AW'(v_sel) - AW'(leak) + AW'(i_sum_excit) + AW'(i_cond_decay)
              - AW'(i_sum_inhibit);

        // Sign bit set -> negative result; any bit above WIDTH -> overflow.
        if (n_sum[AW-1]) begin
            ns = '0;
        end else if (|n_sum[AW-2:WIDTH]) begin
            ns = '1;
        end else begin
            ns = n_sum[WIDTH-1:0];
        end
        fire = (ns >= THRESHOLD);
    end

    // Next-state: refractory countdown runs every edge; the per-channel
    // INTEGRATE/FIRE/REFRACTORY state is fully encoded by rc.
    always_comb begin
        spike_d = '0;
        cnt_d   = cnt_q;
        err_d   = i_valid && !ch_ok;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            v_d[c]  = v_q[c];
            rc_d[c] = (rc_q[c] != '0) ? (rc_q[c] - 1'b1) : rc_q[c];
        end
        if (accept) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (32'(i_ch) == c) begin
                    if (fire) begin
                        v_d[c]     = (RESET_MODE == 1) ? (ns - THRESHOLD) : '0;
                        rc_d[c]    = RCW'(REFRAC_CYCLES);
                        spike_d[c] = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                    end else begin
                        v_d[c] = ns;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                v_q[c]  <= '0;
                rc_q[c] <= '0;
            end
            spike_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                v_q[c]  <= v_d[c];
                rc_q[c] <= rc_d[c];
            end
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        o_voltage = '0;
        o_refrac  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            o_voltage[c*WIDTH +: WIDTH] = v_q[c];
            o_refrac[c]                 = (rc_q[c] != '0);
        end
    end

    assign o_spike     = spike_q;
    assign o_spike_cnt = cnt_q;
    assign o_err       = err_q;

endmodule
